bram_mem_system: RTL and testbench

Parametrised instruction/data memory subsystem for the pipelined RV32 core, replacing the fixed-size imem/dmem pair and the raw instruction-write port. After reset, a valid/ready loader FSM fills instruction BRAM while the core is held in reset. The FSM then releases the core, and the block serves registered instruction fetch with stall/flush and byte/half/word data access. It sits between the core and the board-level program source (UART/JTAG bridge).

---
 rtl/bram_mem_system_pkg.sv | 52 +++++
 rtl/bram_mem_system_sdp.sv | 37 +++
 rtl/bram_mem_system.sv | 151 +++++++++++++++
 tb/tb_bram_mem_system.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bram_mem_system_pkg.sv
// Shared types and helpers for the instruction/data memory subsystem.
// Latency: combinational helpers only.
// Backpressure: none.
// Contents: access-size and FSM enums, default NOP, byte-lane enable, store
// replication and load extraction functions.
package mem_sys_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } accSize_t;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'b00,
      ST_LOAD  = 2'b01,
      ST_RUN   = 2'b10
   } memState_t;

   localparam logic [31:0] DEFAULT_NOP = 32'h0000_0013;

   // Size encoding 2'b11 falls into the default branch and behaves as a word.
   function automatic logic [3:0] laneEnable(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_BYTE: laneEnable = 4'b0001 << off;
         SZ_HALF: laneEnable = off[1] ? 4'b1100 : 4'b0011;
         default: laneEnable = 4'b1111;
      endcase
   endfunction

   // Store data arrives right-aligned; replicate it so every enabled lane sees it.
   function automatic logic [31:0] storeData(input logic [1:0] size, input logic [31:0] wdata);
      case (size)
         SZ_BYTE: storeData = {4{wdata[7:0]}};
         SZ_HALF: storeData = {2{wdata[15:0]}};
         default: storeData = wdata;
      endcase
   endfunction

   // Right-align and zero-extend the addressed lane(s); sign extension is the core's job.
   function automatic logic [31:0] extractLoad(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off);
      logic [31:0] shifted;
      shifted = word >> {off, 3'b000};
      case (size)
         SZ_BYTE: extractLoad = {24'h0, shifted[7:0]};
         SZ_HALF: extractLoad = off[1] ? {16'h0, word[31:16]} : {16'h0, word[15:0]};
         default: extractLoad = word;
      endcase
   endfunction

endpackage

// File: rtl/bram_mem_system_sdp.sv
// Simple dual-port 32-bit BRAM with byte write enables, read-first.
// Latency: 1 cycle read (registered output, synchronously reset to zero).
// Backpressure: none; rdEn=0 holds the output register.
// Ports: clk, reset, wrEn/wrBe/wrAddr/wrData write port, rdEn/rdAddr/rdData read port.
module bram_sdp #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wrEn,
   input  logic [3:0]    wrBe,
   input  logic [AW-1:0] wrAddr,
   input  logic [31:0]   wrData,
   input  logic          rdEn,
   input  logic [AW-1:0] rdAddr,
   output logic [31:0]   rdData
);

   logic [31:0] mem [DEPTH];

   // Write kept in its own reset-free process so the array maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wrEn) begin
         for (int b = 0; b < 4; b++) begin
            if (wrBe[b]) mem[wrAddr][8*b +: 8] <= wrData[8*b +: 8];
         end
      end
   end

   // Non-blocking read of the pre-write contents gives read-first behaviour.
   always_ff @(posedge clk) begin
      if (reset)     rdData <= '0;
      else if (rdEn) rdData <= mem[rdAddr];
   end

endmodule

// File: rtl/bram_mem_system.sv
// Instruction/data memory subsystem: loader FSM fills imem while holding the core in reset.
// Latency: fetch 1 cycle, data read 1 cycle (M->W), core released 1 cycle after last beat.
// Backpressure: ld_ready only in LOAD; fetch holds on if_stall. Optional MEM_CLEAR_EN zeroes dmem.
// Ports: clk/reset; loader ld_valid/ld_ready/ld_addr/ld_data/ld_last/ld_count; core_reset;
// fetch if_addr/if_stall/if_flush/if_instr; data dm_we/dm_size_m/dm_size_w/dm_addr_m/dm_addr_w/
// dm_wdata/dm_rdata.
module bram_mem_system
   import mem_sys_pkg::*;
#(
   parameter int          IMEM_WORDS = 1024,
   parameter int          DMEM_WORDS = 1024,
   parameter logic [31:0] NOP_INSTR  = DEFAULT_NOP
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          ld_valid,
   output logic                          ld_ready,
   input  logic [31:0]                   ld_addr,
   input  logic [31:0]                   ld_data,
   input  logic                          ld_last,
   output logic [$clog2(IMEM_WORDS):0]   ld_count,
   output logic                          core_reset,
   input  logic [31:0]                   if_addr,
   input  logic                          if_stall,
   input  logic                          if_flush,
   output logic [31:0]                   if_instr,
   input  logic                          dm_we,
   input  logic [1:0]                    dm_size_m,
   input  logic [1:0]                    dm_size_w,
   input  logic [31:0]                   dm_addr_m,
   input  logic [31:0]                   dm_addr_w,
   input  logic [31:0]                   dm_wdata,
   output logic [31:0]                   dm_rdata
);

   localparam int IAW = $clog2(IMEM_WORDS);
   localparam int DAW = $clog2(DMEM_WORDS);
   localparam logic [IAW:0] CNT_MAX = '1;

`ifdef MEM_CLEAR_EN
   localparam memState_t RESET_STATE = ST_CLEAR;
`else
   localparam memState_t RESET_STATE = ST_LOAD;
`endif

   memState_t   stateQ, stateD;
   logic        ldAccept;
   logic        storeEn;
   logic        nopSel;
   logic [31:0] imemQ, dmemQ;
   logic        dmWrEn;
   logic [3:0]  dmWrBe;
   logic [DAW-1:0] dmWrAddr;
   logic [31:0] dmWrData;

   // Gate on reset so the handshake and the core reset are clean during the reset cycle itself.
   assign ld_ready   = (stateQ == ST_LOAD) && !reset;
   assign core_reset = reset || (stateQ != ST_RUN);
   assign ldAccept   = ld_valid && ld_ready;
   assign storeEn    = dm_we && (stateQ == ST_RUN) && !reset;

`ifdef MEM_CLEAR_EN
   logic [DAW-1:0] clrIdx;
   always_ff @(posedge clk) begin
      if (reset)                  clrIdx <= '0;
      else if (stateQ == ST_CLEAR) clrIdx <= clrIdx + 1'b1;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) stateQ <= RESET_STATE;
      else       stateQ <= stateD;
   end

   always_comb begin
      stateD = stateQ;
      case (stateQ)
         ST_CLEAR: begin
`ifdef MEM_CLEAR_EN
            if (clrIdx == DAW'(DMEM_WORDS - 1)) stateD = ST_LOAD;
`else
            stateD = ST_LOAD;
`endif
         end
         ST_LOAD: if (ldAccept && ld_last) stateD = ST_RUN;
         ST_RUN:  stateD = ST_RUN;
         default: stateD = RESET_STATE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)                             ld_count <= '0;
      else if (ldAccept && ld_count != CNT_MAX) ld_count <= ld_count + 1'b1;
   end

   // nopSel stands in for a resettable/flushable instruction register so imem stays a plain BRAM.
   always_ff @(posedge clk) begin
      if (reset)         nopSel <= 1'b1;
      else if (if_flush) nopSel <= 1'b1;
      else if (!if_stall) nopSel <= 1'b0;
   end

   assign if_instr = nopSel ? NOP_INSTR : imemQ;

   bram_sdp #(.DEPTH(IMEM_WORDS)) uImem (
      .clk    (clk),
      .reset  (reset),
      .wrEn   (ldAccept),
      .wrBe   (4'b1111),
      .wrAddr (ld_addr[2 +: IAW]),
      .wrData (ld_data),
      .rdEn   (!if_stall && !if_flush),
      .rdAddr (if_addr[2 +: IAW]),
      .rdData (imemQ)
   );

   always_comb begin
      dmWrEn   = storeEn;
      dmWrBe   = laneEnable(dm_size_m, dm_addr_m[1:0]);
      dmWrAddr = dm_addr_m[2 +: DAW];
      dmWrData = storeData(dm_size_m, dm_wdata);
`ifdef MEM_CLEAR_EN
      if (stateQ == ST_CLEAR && !reset) begin
         dmWrEn   = 1'b1;
         dmWrBe   = 4'b1111;
         dmWrAddr = clrIdx;
         dmWrData = '0;
      end
`endif
   end

   bram_sdp #(.DEPTH(DMEM_WORDS)) uDmem (
      .clk    (clk),
      .reset  (reset),
      .wrEn   (dmWrEn),
      .wrBe   (dmWrBe),
      .wrAddr (dmWrAddr),
      .wrData (dmWrData),
      .rdEn   (1'b1),
      .rdAddr (dm_addr_m[2 +: DAW]),
      .rdData (dmemQ)
   );

   assign dm_rdata = extractLoad(dmemQ, dm_size_w, dm_addr_w[1:0]);

   // Address bits outside the word index are intentionally ignored.
   logic unusedBits;
   assign unusedBits = ^{ld_addr[1:0], ld_addr[31:2+IAW], if_addr[1:0], if_addr[31:2+IAW],
                         dm_addr_m[31:2+DAW], dm_addr_w[31:2]};

endmodule

// File: tb/tb_bram_mem_system.sv
// Directed bench for bram_mem_system with small memories (16 words each).
// Latency: n/a.
// Backpressure: n/a.
module tb_bram_mem_system;

   localparam int IW = 16;
   localparam int DW = 16;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        ld_valid, ld_ready, ld_last;
   logic [31:0] ld_addr, ld_data;
   logic [4:0]  ld_count;
   logic        core_reset;
   logic [31:0] if_addr, if_instr;
   logic        if_stall, if_flush;
   logic        dm_we;
   logic [1:0]  dm_size_m, dm_size_w;
   logic [31:0] dm_addr_m, dm_addr_w, dm_wdata, dm_rdata;

   int nChecks = 0;
   int nPass   = 0;

   bram_mem_system #(.IMEM_WORDS(IW), .DMEM_WORDS(DW), .NOP_INSTR(NOP)) dut (
      .clk        (clk),
      .reset      (reset),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .ld_last    (ld_last),
      .ld_count   (ld_count),
      .core_reset (core_reset),
      .if_addr    (if_addr),
      .if_stall   (if_stall),
      .if_flush   (if_flush),
      .if_instr   (if_instr),
      .dm_we      (dm_we),
      .dm_size_m  (dm_size_m),
      .dm_size_w  (dm_size_w),
      .dm_addr_m  (dm_addr_m),
      .dm_addr_w  (dm_addr_w),
      .dm_wdata   (dm_wdata),
      .dm_rdata   (dm_rdata)
   );

   always #5 clk = ~clk;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      else             nPass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic loadBeat(input logic [31:0] a, input logic [31:0] d, input logic last);
      ld_valid = 1'b1;
      ld_addr  = a;
      ld_data  = d;
      ld_last  = last;
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      dm_we     = 1'b1;
      dm_size_m = sz;
      dm_addr_m = a;
      dm_wdata  = d;
      tick();
      dm_we = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      ld_valid = 1'b0; ld_last = 1'b0; ld_addr = '0; ld_data = '0;
      if_addr = '0; if_stall = 1'b0; if_flush = 1'b0;
      dm_we = 1'b0; dm_size_m = 2'b10; dm_size_w = 2'b10;
      dm_addr_m = '0; dm_addr_w = '0; dm_wdata = '0;

      // Reset state
      tick(); tick();
      checkEq("rst_ld_ready", 32'(ld_ready), 32'd0);
      checkEq("rst_core_reset", 32'(core_reset), 32'd1);
      checkEq("rst_ld_count", 32'(ld_count), 32'd0);
      checkEq("rst_if_instr", if_instr, NOP);
      checkEq("rst_dm_rdata", dm_rdata, 32'd0);

      reset = 1'b0;
      #1;
      checkEq("load_ready_rise", 32'(ld_ready), 32'd1);

      // Address wrap: 4*IW lands on word 0 and overwrites it
      loadBeat(32'h0, 32'h77, 1'b0);
      loadBeat(32'(4 * IW), 32'h99, 1'b0);
      checkEq("midload_count", 32'(ld_count), 32'd2);
      if_addr = 32'h0;
      tick();
      checkEq("wrap_overwrite", if_instr, 32'h99);

      // Reset mid-load
      reset = 1'b1;
      tick();
      checkEq("midrst_count", 32'(ld_count), 32'd0);
      checkEq("midrst_ready", 32'(ld_ready), 32'd0);
      reset = 1'b0;
      #1;
      checkEq("reload_ready", 32'(ld_ready), 32'd1);

      // ld_valid held with no last: count saturates at 31, core stays in reset
      ld_valid = 1'b1; ld_addr = 32'hC; ld_data = 32'h44;
      for (int i = 0; i < 40; i++) tick();
      ld_valid = 1'b0;
      checkEq("sat_count", 32'(ld_count), 32'd31);
      checkEq("sat_ready", 32'(ld_ready), 32'd1);
      checkEq("sat_core_reset", 32'(core_reset), 32'd1);

      reset = 1'b1;
      tick();
      reset = 1'b0;

      // Three-beat program load
      loadBeat(32'h0, 32'h11, 1'b0);
      loadBeat(32'h4, 32'h22, 1'b0);
      loadBeat(32'h8, 32'h33, 1'b1);
      checkEq("prog_count", 32'(ld_count), 32'd3);
      checkEq("run_core_reset", 32'(core_reset), 32'd0);
      checkEq("run_ld_ready", 32'(ld_ready), 32'd0);

      // Fetch
      if_addr = 32'h4; tick();
      checkEq("fetch_4", if_instr, 32'h22);
      if_addr = 32'hC; tick();
      checkEq("fetch_c_retained", if_instr, 32'h44);
      if_addr = 32'h8; tick();
      checkEq("fetch_8", if_instr, 32'h33);

      // Stall holds the instruction while the address moves
      if_stall = 1'b1;
      if_addr = 32'h0; tick();
      checkEq("stall_1", if_instr, 32'h33);
      if_addr = 32'h4; tick();
      checkEq("stall_2", if_instr, 32'h33);
      if_addr = 32'hC; tick();
      checkEq("stall_3", if_instr, 32'h33);
      if_flush = 1'b1; tick();
      checkEq("stall_flush_nop", if_instr, NOP);
      if_flush = 1'b0; if_stall = 1'b0; if_addr = 32'h0; tick();
      checkEq("fetch_after_flush", if_instr, 32'h11);

      // Loader ignored in RUN
      ld_valid = 1'b1; ld_addr = 32'h0; ld_data = 32'hDEAD; tick();
      checkEq("run_ignore_ready", 32'(ld_ready), 32'd0);
      checkEq("run_ignore_count", 32'(ld_count), 32'd3);
      ld_valid = 1'b0; tick();
      checkEq("run_ignore_imem", if_instr, 32'h11);

      // Data stores and sized loads
      store(2'b10, 32'h40, 32'hAABBCCDD);
      store(2'b00, 32'h41, 32'h123456EE);
      dm_addr_m = 32'h40; tick();
      dm_addr_w = 32'h40; dm_size_w = 2'b10; #1;
      checkEq("ld_word", dm_rdata, 32'hAABBEEDD);
      dm_addr_w = 32'h42; dm_size_w = 2'b01; #1;
      checkEq("ld_half_42", dm_rdata, 32'h0000AABB);
      dm_addr_w = 32'h41; dm_size_w = 2'b00; #1;
      checkEq("ld_byte_41", dm_rdata, 32'h000000EE);

      // Read-first on a same-word store
      dm_addr_w = 32'h40; dm_size_w = 2'b10;
      store(2'b10, 32'h40, 32'h01020304);
      checkEq("read_first_old", dm_rdata, 32'hAABBEEDD);
      tick();
      checkEq("read_after_write", dm_rdata, 32'h01020304);

      // Half store at an odd address ignores addr[0]
      store(2'b10, 32'h44, 32'h0);
      store(2'b01, 32'h47, 32'hFFFF5566);
      dm_addr_m = 32'h44; tick();
      dm_addr_w = 32'h44; dm_size_w = 2'b11; #1;
      checkEq("half_store_word", dm_rdata, 32'h55660000);
      dm_addr_w = 32'h46; dm_size_w = 2'b01; #1;
      checkEq("half_store_half", dm_rdata, 32'h00005566);
      dm_addr_w = 32'h47; dm_size_w = 2'b00; #1;
      checkEq("half_store_byte3", dm_rdata, 32'h00000055);
      dm_addr_w = 32'h44; #1;
      checkEq("half_store_byte0", dm_rdata, 32'h00000000);

      // Stores are gated off outside RUN
      dm_addr_w = 32'h40; dm_size_w = 2'b10;
      reset = 1'b1; tick();
      checkEq("rst2_dm_rdata", dm_rdata, 32'd0);
      checkEq("rst2_if_instr", if_instr, NOP);
      reset = 1'b0;
      store(2'b10, 32'h40, 32'hFFFFFFFF);
      dm_addr_m = 32'h40; tick();
      checkEq("store_gated_load", dm_rdata, 32'h01020304);
      checkEq("store_gated_core_reset", 32'(core_reset), 32'd1);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
